apb_sram_arbiter: RTL and testbench
===================================

Name: apb_sram_arbiter

Overview:
- Round-robin arbiter and APB master sequencer that shares one APB SRAM slave (apb_sramc) among NUM_REQ on-chip requesters.
- Each requester has a simple valid/ready request port; the arbiter grants one at a time, latches its command and runs a full APB SETUP/ACCESS transfer.
- Returns read data and a one-cycle completion pulse to the granted requester.
- Sits between DMA/debug/boot-loader requesters and apb_sramc in the on-chip RAM subsystem.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- ADDR_WIDTH, 32, APB/requester address width.
- DATA_WIDTH, 8, data width; byte access only.
- TIMEOUT_CYCLES, 16, ACCESS-phase watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; port i at [i*AW +: AW].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  DATA_WIDTH  read data, valid with req_ready of a read.
- rsp_err  out  NUM_REQ  one-cycle timeout error pulse; constant 0 without the feature.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  ADDR_WIDTH  APB address.
- pwrite  out  1  APB write.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  1  APB ready.
- prdata  in  DATA_WIDTH  APB read data.

Behaviour:
- Reset values: psel, penable, pwrite, paddr, pwdata, req_ready, rsp_err and rsp_rdata are all 0; state = IDLE.
- Reset sets the grant pointer last_gnt = NUM_REQ-1, so port 0 has first priority.
- All outputs are registered.
- FSM IDLE:
  - If any req_valid is set, pick the winner by scanning from (last_gnt+1) mod NUM_REQ upward with wrap-around.
  - Latch the winner index, addr, write and wdata into paddr/pwrite/pwdata.
  - Set psel=1, penable=0; go to SETUP.
- FSM SETUP: exactly one cycle; set penable=1; go to ACCESS.
- FSM ACCESS: hold psel=1, penable=1 and all command fields until pready=1. In the pready cycle:
  - Register req_ready[win]=1 for the next cycle.
  - If it is a read, register rsp_rdata <= prdata.
  - Set last_gnt = win; drop psel and penable; go to IDLE.
- Every transfer passes through IDLE with psel=0 for at least one cycle, so the slave FSM always returns to its idle state. There are no back-to-back transfers.
- Latency with apb_sramc (pready in the second ACCESS cycle):
  - req_valid sampled in cycle 0.
  - psel in cycle 1, penable in cycle 2, pready in cycle 3.
  - req_ready pulse in cycle 4.
  - Next grant decision in cycle 4, next psel in cycle 5.
- Requester rules:
  - A requester holds req_valid until its req_ready pulse.
  - Commands are latched at grant. A requester that drops req_valid or changes fields mid-transfer does not affect the transfer, and its completion pulse still fires.
  - A requester still asserting req_valid in the req_ready cycle is treated as a new request.
- rsp_rdata holds its value until the next completed read. Writes and timeouts leave it unchanged.
- Fairness: with all ports requesting continuously, grants rotate 0,1,2,3,0,...; a requester waits at most NUM_REQ-1 transfers.
- Reset asserted mid-transfer: immediate return to the reset values. No ready or err pulse is issued for the aborted transfer.
- The widths of win and last_gnt are $clog2(NUM_REQ); pointer increment wraps modulo NUM_REQ (non-power-of-two supported).

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
- With the macro: a counter clears on entry to ACCESS and increments each ACCESS cycle without pready. When it reaches TIMEOUT_CYCLES:
  - Drop psel and penable.
  - Pulse req_ready[win] and rsp_err[win] together for one cycle; rsp_rdata is unchanged.
  - Update last_gnt; go to IDLE.
  - If pready arrives in the same cycle as the limit, pready wins and no error is raised.
- Without the macro: ACCESS waits indefinitely, rsp_err is constant 0, and no counter is built.

Decomposition:
- Package apb_arb_pkg: state encoding IDLE=0, SETUP=1, ACCESS=2; function rr_next(pointer, req vector) width helpers.
- Sub-module apb_rr_picker: combinational round-robin winner index plus any-valid flag from req_valid and last_gnt.
- Top module contains the FSM, command registers and the optional watchdog.

Test Plan:
- Single read: port 2 reads addr 0x10, with the slave returning 0xA5 -> psel in cycle 1, penable in cycle 2, req_ready[2] in cycle 4, rsp_rdata=0xA5, rsp_err=0.
- Single write: port 0 writes 0x3C to 0x20 -> paddr=0x20, pwrite=1, pwdata=0x3C stable across SETUP/ACCESS; req_ready=4'b0001 pulse; rsp_rdata unchanged.
- Contention: all 4 ports request continuously from reset -> grant order 0,1,2,3,0; psel low for at least 1 cycle between each transfer.
- Wrap and skip: last_gnt=2, only ports 1 and 3 requesting -> port 3 served first, then port 1.
- Reset mid-ACCESS: rstn low while penable=1 -> all outputs 0 immediately; after release, port 0 wins first.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held low -> after 16 ACCESS cycles, psel drops and req_ready[win] and rsp_err[win] pulse together. Without the macro, the same stimulus holds psel high indefinitely.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// ============================================================================
// Module : apb_arb_pkg
// Brief  : State encoding and round-robin helper for apb_sram_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_arb_pkg;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;

    localparam int unsigned c_MAX_REQ = 8;

    // First requester at or after ptr+1 (mod n); returns ptr when none is set.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input logic [c_MAX_REQ-1:0] req,
                                            input int unsigned n);
        int unsigned idx;
        int unsigned res;
        logic        found;
        res   = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= c_MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if ((k <= n) && !found && req[3'(idx)]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_rr_picker.sv
// ============================================================================
// Module : apb_rr_picker
// Brief  : Combinational round-robin winner index and any-valid flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [PTR_W-1:0]   last_gnt_i,
    output logic [PTR_W-1:0]   win_o,
    output logic               any_o
);

    logic [c_MAX_REQ-1:0] w_req;

    always_comb begin
        w_req                = '0;
        w_req[NUM_REQ-1:0]   = req_valid_i;
    end

    assign win_o = PTR_W'(rr_next(32'(last_gnt_i), w_req, 32'(NUM_REQ)));
    assign any_o = |req_valid_i;

endmodule

`default_nettype wire

// File: rtl/apb_sram_arbiter.sv
// ============================================================================
// Module : apb_sram_arbiter
// Brief  : Round-robin arbiter + APB master sequencer for one APB SRAM slave.
//          Optional ACCESS watchdog enabled by macro APB_ARB_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_sram_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [NUM_REQ-1:0]            rsp_err,
    output logic                          psel,
    output logic                          penable,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          pwrite,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic                          pready,
    input  logic [DATA_WIDTH-1:0]         prdata
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("apb_sram_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      win_q, win_d;
    logic [PTR_W-1:0]      last_gnt_q, last_gnt_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_REQ-1:0]    ready_q, ready_d;
    logic [PTR_W-1:0]      w_win;
    logic                  w_any;
    logic                  w_timeout;

    apb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_valid_i (req_valid),
        .last_gnt_i  (last_gnt_q),
        .win_o       (w_win),
        .any_o       (w_any)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= c_IDLE;
            win_q      <= '0;
            last_gnt_q <= PTR_W'(NUM_REQ - 1);
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            rdata_q    <= '0;
            ready_q    <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            last_gnt_q <= last_gnt_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (w_any) state_d = c_SETUP;
            c_SETUP:  state_d = c_ACCESS;
            c_ACCESS: if (pready || w_timeout) state_d = c_IDLE;
            default:  state_d = c_IDLE;
        endcase
    end

    always_comb begin
        win_d      = win_q;
        last_gnt_d = last_gnt_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        rdata_d    = rdata_q;
        ready_d    = '0;
        case (state_q)
            c_IDLE: begin
                if (w_any) begin
                    win_d     = w_win;
                    paddr_d   = req_addr[32'(w_win) * ADDR_WIDTH +: ADDR_WIDTH];
                    pwrite_d  = req_write[w_win];
                    pwdata_d  = req_wdata[32'(w_win) * DATA_WIDTH +: DATA_WIDTH];
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            c_SETUP: penable_d = 1'b1;
            c_ACCESS: begin
                // pready takes precedence: w_timeout is only ever set without it
                if (pready || w_timeout) begin
                    ready_d[win_q] = 1'b1;
                    if (pready && !pwrite_q) rdata_d = prdata;
                    last_gnt_d = win_q;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] err_q, err_d;

    assign w_timeout = (state_q == c_ACCESS) && !pready &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = '0;
        if (state_q == c_SETUP) begin
            cnt_d = '0;
        end else if ((state_q == c_ACCESS) && !pready) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (w_timeout) err_d[win_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = '0;
`endif

    assign req_ready = ready_q;
    assign rsp_rdata = rdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_sram_arbiter.sv
// ============================================================================
// Module : tb_apb_sram_arbiter
// Brief  : Directed, table-driven bench for apb_sram_arbiter with a small
//          APB SRAM slave model (pready in the second ACCESS cycle).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_sram_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   req_valid, req_write;
    logic [127:0] req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_ready, rsp_err;
    logic [7:0]   rsp_rdata;
    logic         psel, penable, pwrite, pready;
    logic [31:0]  paddr;
    logic [7:0]   pwdata, prdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apb_sram_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );

    // Slave model
    logic       acc_seen;
    logic       hang;
    logic [7:0] mem [256];

    assign pready = psel && penable && acc_seen && !hang;
    assign prdata = mem[paddr[7:0]];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_seen <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hA5;
        end else begin
            acc_seen <= psel && penable && !pready;
            if (psel && penable && pready && pwrite) mem[paddr[7:0]] <= pwdata;
        end
    end

    typedef struct {
        int         port;
        logic       wr;
        logic [31:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];
    int   order_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        req_valid = 4'b0001 << v.port;
        req_write[v.port] = v.wr;
        req_addr[v.port*32 +: 32] = v.addr;
        req_wdata[v.port*8 +: 8] = v.wdata;
        check("idle_psel", 64'(psel), 64'd0);
        tick();
        check("c1_psel", 64'({psel, penable}), 64'b10);
        check("c1_paddr", 64'(paddr), 64'(v.addr));
        check("c1_pwrite", 64'(pwrite), 64'(v.wr));
        if (v.wr) check("c1_pwdata", 64'(pwdata), 64'(v.wdata));
        tick();
        check("c2_penable", 64'({psel, penable}), 64'b11);
        tick();
        check("c3_hold", 64'({psel, penable, paddr, pwrite}), {30'd0, 2'b11, v.addr, v.wr});
        if (v.wr) check("c3_pwdata", 64'(pwdata), 64'(v.wdata));
        check("c3_noready", 64'(req_ready), 64'd0);
        tick();
        check("c4_ready", 64'(req_ready), 64'(4'b0001 << v.port));
        check("c4_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
        check("c4_err", 64'(rsp_err), 64'd0);
        check("c4_psel", 64'(psel), 64'd0);
        req_valid = 4'b0000;
        tick();
        check("c5_ready", 64'(req_ready), 64'd0);
        check("c5_psel", 64'(psel), 64'd0);
    endtask

    // Hold mask asserted, record served ports; optionally drop a port once served.
    task automatic serve(input logic [3:0] mask, input int nserve, input bit drop);
        int budget;
        order_q.delete();
        req_valid = mask;
        budget = 0;
        while (order_q.size() < nserve && budget < 200) begin
            tick();
            budget++;
            if (req_ready != 4'b0000) begin
                check("ready_onehot", 64'($countones(req_ready)), 64'd1);
                check("psel_gap", 64'(psel), 64'd0);
                for (int i = 0; i < 4; i++) begin
                    if (req_ready[i]) begin
                        order_q.push_back(i);
                        if (drop) req_valid[i] = 1'b0;
                    end
                end
            end
        end
        if (order_q.size() < nserve) begin
            n_tests++;
            n_fail++;
            $display("FAIL serve_timeout: got %0d grants expected %0d", order_q.size(), nserve);
        end
        req_valid = 4'b0000;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = 4'b0000;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        int budget;
        int acc_cnt;
        int exp_order [5];

        rstn = 1'b0;
        hang = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;

        vecs[0] = '{2, 1'b0, 32'h10, 8'h00, 8'hA5};
        vecs[1] = '{0, 1'b1, 32'h20, 8'h3C, 8'hA5};
        vecs[2] = '{1, 1'b0, 32'h20, 8'h00, 8'h3C};
        vecs[3] = '{3, 1'b1, 32'h7F, 8'hFF, 8'h3C};
        vecs[4] = '{3, 1'b0, 32'h7F, 8'h00, 8'hFF};
        vecs[5] = '{0, 1'b0, 32'h00, 8'h00, 8'h00};

        tick();
        tick();
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // last_gnt = 2 after this; ports 1 and 3 then compete
        run_txn(vecs[0]);
        serve(4'b1010, 2, 1'b1);
        check("wrap_first", 64'(order_q.size() > 0 ? order_q[0] : -1), 64'd3);
        check("wrap_second", 64'(order_q.size() > 1 ? order_q[1] : -1), 64'd1);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_write[i] = 1'b0;
            req_addr[i*32 +: 32] = 32'h10;
        end
        exp_order = '{0, 1, 2, 3, 0};
        serve(4'b1111, 5, 1'b0);
        for (int i = 0; i < 5; i++)
            check("rr_order", 64'(order_q.size() > i ? order_q[i] : -1), 64'(exp_order[i]));
        tick();
        tick();

        // Reset in ACCESS: last_gnt is 0 here, so port 3 would win without the reset
        req_valid = 4'b0010;
        budget = 0;
        while (!penable && budget < 20) begin tick(); budget++; end
        check("mid_reach_access", 64'(penable), 64'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_psel", 64'({psel, penable}), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        check("mid_rst_rdata", 64'(rsp_rdata), 64'd0);
        check("mid_rst_paddr", 64'(paddr), 64'd0);
        req_valid = 4'b0000;
        tick();
        check("mid_rst_noready", 64'(req_ready), 64'd0);
        rstn = 1'b1;
        tick();
        serve(4'b1001, 1, 1'b1);
        check("post_rst_winner", 64'(order_q.size() > 0 ? order_q[0] : -1), 64'd0);
        tick();

        // Hung slave
        hang = 1'b1;
        req_valid = 4'b0100;
        req_write[2] = 1'b0;
        acc_cnt = 0;
        budget = 0;
        while (!(req_ready != 4'b0000) && budget < 60) begin
            tick();
            budget++;
            if (req_ready == 4'b0000 && penable) acc_cnt++;
        end
`ifdef APB_ARB_TIMEOUT_EN
        check("to_access_cycles", 64'(acc_cnt), 64'd16);
        check("to_ready", 64'(req_ready), 64'b0100);
        check("to_err", 64'(rsp_err), 64'b0100);
        check("to_psel", 64'({psel, penable}), 64'd0);
        check("to_rdata", 64'(rsp_rdata), 64'hA5);
        req_valid = 4'b0000;
        tick();
        check("to_err_pulse", 64'(rsp_err), 64'd0);
`else
        check("hang_psel", 64'({psel, penable}), 64'b11);
        check("hang_err", 64'(rsp_err), 64'd0);
        check("hang_ready", 64'(req_ready), 64'd0);
        check("hang_rdata", 64'(rsp_rdata), 64'hA5);
`endif
        hang = 1'b0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
